// File: rtl/cr16_control_fsm.sv
// ---------------------------------------------------------------------------
// cr16_control_fsm
//
// Multi-cycle CR16 controller. Fetches one instruction at a time from a
// synchronous-read memory, decodes it, and drives the datapath control
// bundle. It also sequences the register, flag and memory write strobes and
// keeps the program counter.
//
// Sequence: FETCH -> DECODE -> EXECUTE [-> WRITEBACK for LOAD] -> FETCH
//
// Optional build macro:
//   CR16_CTRL_HALT_ON_ILLEGAL_EN
//     Defined   : an illegal op (10..15) in EXECUTE enters HALT. HALT makes no
//                 writes, holds the PC, drives O_HALTED=1 and is left only by
//                 reset.
//     Undefined : illegal ops behave as NOP, HALT is unreachable and
//                 O_HALTED is tied 0.
//
// Parameters:
//   PC_RESET              PC value loaded on reset
//
// Ports:
//   I_CLK                 clock, rising edge
//   I_NRESET              asynchronous active-low reset
//   I_ENABLE              0 = freeze state/PC/IR and suppress all write strobes
//   I_MEM_DATA[15:0]      memory read data (1-cycle read latency)
//   I_A[15:0]             datapath O_A (load/store address, jump target)
//   I_STATUS_FLAGS[4:0]   datapath flags {C,L,F,Z,N}
//   O_MEM_ADDR[15:0]      memory address
//   O_MEM_WE              memory write strobe
//   O_REG_WRITE_ENABLE    one-hot register write enable
//   O_REG_A_SELECT        datapath A select
//   O_REG_B_SELECT        datapath B select
//   O_IMMEDIATE_SELECT    datapath B operand = O_IMMEDIATE
//   O_IMMEDIATE[15:0]     extended immediate
//   O_OPCODE[3:0]         ALU opcode
//   O_FLAGS_WRITE_ENABLE  latch ALU flags this cycle
//   O_REGFILE_DATA[15:0]  alternate register write data
//   O_REGFILE_DATA_SELECT register write source = O_REGFILE_DATA
//   O_PC[15:0]            current PC
//   O_STATE[2:0]          FETCH=0 DECODE=1 EXECUTE=2 WRITEBACK=3 HALT=4
//   O_HALTED              1 while in HALT
// ---------------------------------------------------------------------------
module cr16_control_fsm #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        I_CLK,
    input  logic        I_NRESET,
    input  logic        I_ENABLE,
    input  logic [15:0] I_MEM_DATA,
    input  logic [15:0] I_A,
    input  logic [4:0]  I_STATUS_FLAGS,
    output logic [15:0] O_MEM_ADDR,
    output logic        O_MEM_WE,
    output logic [15:0] O_REG_WRITE_ENABLE,
    output logic [3:0]  O_REG_A_SELECT,
    output logic [3:0]  O_REG_B_SELECT,
    output logic        O_IMMEDIATE_SELECT,
    output logic [15:0] O_IMMEDIATE,
    output logic [3:0]  O_OPCODE,
    output logic        O_FLAGS_WRITE_ENABLE,
    output logic [15:0] O_REGFILE_DATA,
    output logic        O_REGFILE_DATA_SELECT,
    output logic [15:0] O_PC,
    output logic [2:0]  O_STATE,
    output logic        O_HALTED
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    // Major opcodes
    localparam logic [3:0] OP_RR    = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_MOVI  = 4'd2;
    localparam logic [3:0] OP_LUI   = 4'd3;
    localparam logic [3:0] OP_CMPI  = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STOR  = 4'd6;
    localparam logic [3:0] OP_BCOND = 4'd7;
    localparam logic [3:0] OP_JCOND = 4'd8;
    localparam logic [3:0] OP_JAL   = 4'd9;

    // ALU opcodes used directly by the controller
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] EXT_MOV  = 4'd15;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [15:0] w_next_pc;
    logic [15:0] r_ir;

    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_ext;
    logic [3:0]  w_rs;
    logic [7:0]  w_imm8;
    logic [15:0] w_simm;
    logic [15:0] w_rd_onehot;
    logic [15:0] w_pc_inc;
    logic        w_cond_true;

    logic [15:0] w_mem_addr;
    logic        w_mem_we;
    logic [15:0] w_reg_we;
    logic [3:0]  w_a_sel;
    logic [3:0]  w_b_sel;
    logic        w_imm_sel;
    logic [15:0] w_imm;
    logic [3:0]  w_opcode;
    logic        w_flags_we;
    logic [15:0] w_rf_data;
    logic        w_rf_sel;
`ifdef CR16_CTRL_HALT_ON_ILLEGAL_EN
    logic        w_halted;
`endif

    // Branch/jump condition evaluation on {C,L,F,Z,N}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] flags);
        logic res;
        case (cond)
            4'd0:    res = flags[1];
            4'd1:    res = ~flags[1];
            4'd2:    res = flags[4];
            4'd3:    res = ~flags[4];
            4'd4:    res = flags[3];
            4'd5:    res = ~flags[3];
            4'd6:    res = flags[0];
            4'd7:    res = ~flags[0];
            4'd8:    res = flags[2];
            4'd9:    res = ~flags[2];
            4'd14:   res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_op        = r_ir[15:12];
    assign w_rd        = r_ir[11:8];
    assign w_ext       = r_ir[7:4];
    assign w_rs        = r_ir[3:0];
    assign w_imm8      = r_ir[7:0];
    assign w_simm      = {{8{w_imm8[7]}}, w_imm8};
    assign w_rd_onehot = 16'h0001 << w_rd;
    assign w_pc_inc    = r_pc + 16'h0001;
    assign w_cond_true = cond_eval(w_rd, I_STATUS_FLAGS);

    // Next-state, next-PC and datapath controls decoded from state and IR
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_mem_addr   = r_pc;
        w_mem_we     = 1'b0;
        w_reg_we     = 16'h0000;
        w_a_sel      = 4'h0;
        w_b_sel      = 4'h0;
        w_imm_sel    = 1'b0;
        w_imm        = 16'h0000;
        w_opcode     = 4'h0;
        w_flags_we   = 1'b0;
        w_rf_data    = 16'h0000;
        w_rf_sel     = 1'b0;
`ifdef CR16_CTRL_HALT_ON_ILLEGAL_EN
        w_halted     = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_state = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_next_state = S_FETCH;
                w_next_pc    = w_pc_inc;
                case (w_op)
                    OP_RR: begin
                        if (w_ext == EXT_MOV) begin
                            // MOV routes Rs through the A port straight into Rd
                            w_a_sel   = w_rs;
                            w_rf_data = I_A;
                            w_rf_sel  = 1'b1;
                            w_reg_we  = w_rd_onehot;
                        end else begin
                            w_a_sel    = w_rd;
                            w_b_sel    = w_rs;
                            w_opcode   = w_ext;
                            w_reg_we   = w_rd_onehot;
                            w_flags_we = 1'b1;
                        end
                    end
                    OP_ADDI: begin
                        w_a_sel    = w_rd;
                        w_imm_sel  = 1'b1;
                        w_imm      = w_simm;
                        w_opcode   = ALU_ADD;
                        w_reg_we   = w_rd_onehot;
                        w_flags_we = 1'b1;
                    end
                    OP_MOVI: begin
                        w_rf_data = {8'h00, w_imm8};
                        w_rf_sel  = 1'b1;
                        w_reg_we  = w_rd_onehot;
                    end
                    OP_LUI: begin
                        w_rf_data = {w_imm8, 8'h00};
                        w_rf_sel  = 1'b1;
                        w_reg_we  = w_rd_onehot;
                    end
                    OP_CMPI: begin
                        w_a_sel    = w_rd;
                        w_imm_sel  = 1'b1;
                        w_imm      = w_simm;
                        w_opcode   = ALU_SUB;
                        w_flags_we = 1'b1;
                    end
                    OP_LOAD: begin
                        // Read data arrives next cycle; PC advances after WRITEBACK
                        w_a_sel      = w_rs;
                        w_mem_addr   = I_A;
                        w_next_state = S_WRITEBACK;
                        w_next_pc    = r_pc;
                    end
                    OP_STOR: begin
                        w_a_sel    = w_rs;
                        w_b_sel    = w_rd;
                        w_mem_addr = I_A;
                        w_mem_we   = 1'b1;
                    end
                    OP_BCOND: begin
                        if (w_cond_true) begin
                            w_next_pc = r_pc + w_simm;
                        end else begin
                            w_next_pc = w_pc_inc;
                        end
                    end
                    OP_JCOND: begin
                        w_a_sel = w_rs;
                        if (w_cond_true) begin
                            w_next_pc = I_A;
                        end else begin
                            w_next_pc = w_pc_inc;
                        end
                    end
                    OP_JAL: begin
                        // I_A is the pre-edge Rs, so Rd==Rs still jumps to the old value
                        w_a_sel   = w_rs;
                        w_rf_data = w_pc_inc;
                        w_rf_sel  = 1'b1;
                        w_reg_we  = w_rd_onehot;
                        w_next_pc = I_A;
                    end
                    default: begin
`ifdef CR16_CTRL_HALT_ON_ILLEGAL_EN
                        w_next_state = S_HALT;
                        w_next_pc    = r_pc;
`else
                        w_next_pc    = w_pc_inc;
`endif
                    end
                endcase
            end
            S_WRITEBACK: begin
                w_a_sel      = w_rs;
                w_mem_addr   = I_A;
                w_rf_data    = I_MEM_DATA;
                w_rf_sel     = 1'b1;
                w_reg_we     = w_rd_onehot;
                w_next_state = S_FETCH;
                w_next_pc    = w_pc_inc;
            end
            S_HALT: begin
`ifdef CR16_CTRL_HALT_ON_ILLEGAL_EN
                w_halted     = 1'b1;
                w_next_state = S_HALT;
`else
                w_next_state = S_FETCH;
`endif
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // State, PC and instruction register; all frozen while disabled
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_state <= S_FETCH;
            r_pc    <= PC_RESET;
            r_ir    <= 16'h0000;
        end else if (I_ENABLE) begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (r_state == S_DECODE) begin
                r_ir <= I_MEM_DATA;
            end else begin
                r_ir <= r_ir;
            end
        end else begin
            r_state <= r_state;
            r_pc    <= r_pc;
            r_ir    <= r_ir;
        end
    end

    assign O_MEM_ADDR            = w_mem_addr;
    assign O_MEM_WE              = w_mem_we & I_ENABLE;
    assign O_REG_WRITE_ENABLE    = I_ENABLE ? w_reg_we : 16'h0000;
    assign O_REG_A_SELECT        = w_a_sel;
    assign O_REG_B_SELECT        = w_b_sel;
    assign O_IMMEDIATE_SELECT    = w_imm_sel;
    assign O_IMMEDIATE           = w_imm;
    assign O_OPCODE              = w_opcode;
    assign O_FLAGS_WRITE_ENABLE  = w_flags_we & I_ENABLE;
    assign O_REGFILE_DATA        = w_rf_data;
    assign O_REGFILE_DATA_SELECT = w_rf_sel;
    assign O_PC                  = r_pc;
    assign O_STATE               = r_state;
`ifdef CR16_CTRL_HALT_ON_ILLEGAL_EN
    assign O_HALTED              = w_halted;
`else
    assign O_HALTED              = 1'b0;
`endif

endmodule

// File: tb/tb_cr16_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cr16_control_fsm
//
// Bench for cr16_control_fsm. It surrounds the controller with a small
// memory and a register-file/adder datapath model. A scoreboard of expected
// per-instruction results (register write, data, memory write count, flag
// write, next PC) is filled as each program phase is set up. The entries are
// popped when the controller returns to FETCH after the instruction.
// ---------------------------------------------------------------------------
module tb_cr16_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] mem_q;
    logic [15:0] a_bus;
    logic [4:0]  flags;

    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] reg_we;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        imm_sel;
    logic [15:0] imm;
    logic [3:0]  opcode;
    logic        fwe;
    logic [15:0] rf_data;
    logic        rf_sel;
    logic [15:0] pc;
    logic [2:0]  state;
    logic        halted;

    logic [15:0] mem [0:1023];
    logic [15:0] rf  [0:15];
    logic [15:0] b_bus;
    logic [15:0] alu_out;
    logic [15:0] wdata;

    int n_checks = 0;
    int n_pass   = 0;
    bit sb_en    = 1'b0;

    typedef struct {
        logic [15:0] we;
        logic [15:0] data;
        int          memwe;
        logic        fw;
        logic [15:0] pc;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cr16_control_fsm #(.PC_RESET(16'h0000)) dut (
        .I_CLK                 (clk),
        .I_NRESET              (rst_n),
        .I_ENABLE              (en),
        .I_MEM_DATA            (mem_q),
        .I_A                   (a_bus),
        .I_STATUS_FLAGS        (flags),
        .O_MEM_ADDR            (mem_addr),
        .O_MEM_WE              (mem_we),
        .O_REG_WRITE_ENABLE    (reg_we),
        .O_REG_A_SELECT        (a_sel),
        .O_REG_B_SELECT        (b_sel),
        .O_IMMEDIATE_SELECT    (imm_sel),
        .O_IMMEDIATE           (imm),
        .O_OPCODE              (opcode),
        .O_FLAGS_WRITE_ENABLE  (fwe),
        .O_REGFILE_DATA        (rf_data),
        .O_REGFILE_DATA_SELECT (rf_sel),
        .O_PC                  (pc),
        .O_STATE               (state),
        .O_HALTED              (halted)
    );

    // Datapath model: only ADD is needed by the programs below
    assign a_bus   = rf[a_sel];
    assign b_bus   = imm_sel ? imm : rf[b_sel];
    assign alu_out = (opcode == 4'd0) ? (a_bus + b_bus) : 16'h0000;
    assign wdata   = rf_sel ? rf_data : alu_out;

    always @(posedge clk) mem_q <= mem[mem_addr[9:0]];

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (reg_we[i]) rf[i] <= wdata;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] we, input logic [15:0] d, input int mwe,
                        input logic fw, input logic [15:0] p);
        exp_t e;
        e.we = we; e.data = d; e.memwe = mwe; e.fw = fw; e.pc = p;
        sb_q.push_back(e);
    endtask

    task automatic wait_for(input logic [2:0] s, input logic [15:0] p, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk); #1;
            if (state == s && pc == p) found = 1'b1;
        end
        chk_eq(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb_q.size() != 0 && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        chk_eq(tag, sb_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: accumulate strobes through EXECUTE/WRITEBACK, compare on return to FETCH
    initial begin : monitor
        logic [15:0] acc_we;
        logic [15:0] acc_data;
        int          acc_memwe;
        logic        acc_fw;
        bit          in_instr;
        exp_t        e;
        acc_we = 16'h0000; acc_data = 16'h0000; acc_memwe = 0; acc_fw = 1'b0; in_instr = 1'b0;
        forever begin
            @(negedge clk);
            if (!sb_en || !rst_n) begin
                acc_we = 16'h0000; acc_data = 16'h0000; acc_memwe = 0; acc_fw = 1'b0; in_instr = 1'b0;
            end else if (state == 3'd2 || state == 3'd3) begin
                in_instr  = 1'b1;
                acc_we    = acc_we | reg_we;
                if (reg_we != 16'h0000) acc_data = wdata;
                acc_memwe = acc_memwe + int'(mem_we);
                acc_fw    = acc_fw | fwe;
            end else if (in_instr && state == 3'd0) begin
                if (sb_q.size() == 0) begin
                    chk_eq("sb_extra_instr", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk_eq($sformatf("sb_we->%0h", e.pc), acc_we, e.we);
                    if (e.we != 16'h0000) chk_eq($sformatf("sb_wdata->%0h", e.pc), acc_data, e.data);
                    chk_eq($sformatf("sb_memwe->%0h", e.pc), acc_memwe, e.memwe);
                    chk_eq($sformatf("sb_flagwe->%0h", e.pc), acc_fw, e.fw);
                    chk_eq($sformatf("sb_pc->%0h", e.pc), pc, e.pc);
                end
                acc_we = 16'h0000; acc_data = 16'h0000; acc_memwe = 0; acc_fw = 1'b0; in_instr = 1'b0;
            end
        end
    end

    initial begin
        // Fill with never-taken branches so stray fetches are harmless NOPs
        for (int i = 0; i < 1024; i++) mem[i] = 16'h7F00;
        mem[10'h000] = 16'h2105;  // MOVI R1,5
        mem[10'h001] = 16'h1103;  // ADDI R1,3
        mem[10'h002] = 16'h2340;  // MOVI R3,0x40
        mem[10'h003] = 16'h5203;  // LOAD R2,[R3]
        mem[10'h004] = 16'h3401;  // LUI  R4,0x01
        mem[10'h005] = 16'h6103;  // STOR R1,[R3]
        mem[10'h006] = 16'h0101;  // ADD  R1,R1
        mem[10'h007] = 16'h05F4;  // MOV  R5,R4
        mem[10'h008] = 16'h4101;  // CMPI R1,1
        mem[10'h009] = 16'h2620;  // MOVI R6,0x20
        mem[10'h00A] = 16'h70FE;  // BEQ  -2
        mem[10'h00B] = 16'h8E06;  // JUC  R6
        mem[10'h020] = 16'h9F04;  // JAL  R15,R4
        mem[10'h040] = 16'hBEEF;  // load data
        mem[10'h100] = 16'h9444;  // JAL  R4,R4
        mem[10'h101] = 16'h8F06;  // Jcond never
        mem[10'h102] = 16'h28FF;  // MOVI R8,0xFF
        mem[10'h103] = 16'h37FF;  // LUI  R7,0xFF
        mem[10'h104] = 16'h0708;  // ADD  R7,R8
        mem[10'h105] = 16'h8E07;  // JUC  R7 -> 0xFFFF
        mem[10'h3FF] = 16'h7F00;  // at 0xFFFF: never-taken branch

        rst_n = 1'b0;
        en    = 1'b1;
        flags = 5'b00010;  // Z=1

        repeat (2) @(negedge clk);
        #1;
        chk_eq("rst_pc",      pc,       32'h0000);
        chk_eq("rst_state",   state,    32'd0);
        chk_eq("rst_reg_we",  reg_we,   32'h0000);
        chk_eq("rst_mem_we",  mem_we,   32'd0);
        chk_eq("rst_flag_we", fwe,      32'd0);
        chk_eq("rst_rf_sel",  rf_sel,   32'd0);
        chk_eq("rst_halted",  halted,   32'd0);
        chk_eq("rst_memaddr", mem_addr, 32'h0000);

        push(16'h0002, 16'h0005, 0, 1'b0, 16'h0001);
        push(16'h0002, 16'h0008, 0, 1'b1, 16'h0002);
        push(16'h0008, 16'h0040, 0, 1'b0, 16'h0003);
        push(16'h0004, 16'hBEEF, 0, 1'b0, 16'h0004);
        push(16'h0010, 16'h0100, 0, 1'b0, 16'h0005);
        push(16'h0000, 16'h0000, 1, 1'b0, 16'h0006);
        push(16'h0002, 16'h0010, 0, 1'b1, 16'h0007);
        push(16'h0020, 16'h0100, 0, 1'b0, 16'h0008);
        push(16'h0000, 16'h0000, 0, 1'b1, 16'h0009);
        push(16'h0040, 16'h0020, 0, 1'b0, 16'h000A);
        push(16'h0000, 16'h0000, 0, 1'b0, 16'h0008);  // BEQ taken: 10-2

        sb_en = 1'b1;
        rst_n = 1'b1;

        wait_for(3'd2, 16'h0003, "load_exec_reached");
        chk_eq("load_exec_addr", mem_addr, 32'h0040);
        chk_eq("load_exec_we",   reg_we,   32'h0000);
        @(negedge clk); #1;
        chk_eq("load_wb_state",  state,    32'd3);
        chk_eq("load_wb_data",   rf_data,  32'hBEEF);
        chk_eq("load_wb_we",     reg_we,   32'h0004);
        chk_eq("load_wb_sel",    rf_sel,   32'd1);

        wait_for(3'd1, 16'h0005, "stor_decode_reached");
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk); #1;
        chk_eq("stor_dis_memwe", mem_we,   32'd0);
        chk_eq("stor_dis_state", state,    32'd2);
        chk_eq("stor_dis_addr",  mem_addr, 32'h0040);
        repeat (3) @(negedge clk);
        #1;
        chk_eq("stor_hold_state", state, 32'd2);
        chk_eq("stor_hold_pc",    pc,    32'h0005);
        @(posedge clk); #1;
        en = 1'b1;

        drain("phase1_drain");

        flags = 5'b00000;  // Z=0
        push(16'h0000, 16'h0000, 0, 1'b1, 16'h0009);
        push(16'h0040, 16'h0020, 0, 1'b0, 16'h000A);
        push(16'h0000, 16'h0000, 0, 1'b0, 16'h000B);  // BEQ not taken
        push(16'h0000, 16'h0000, 0, 1'b0, 16'h0020);
        push(16'h8000, 16'h0021, 0, 1'b0, 16'h0100);
        push(16'h0010, 16'h0101, 0, 1'b0, 16'h0100);  // JAL R4,R4 uses old R4
        push(16'h0010, 16'h0101, 0, 1'b0, 16'h0101);
        push(16'h0000, 16'h0000, 0, 1'b0, 16'h0102);
        push(16'h0100, 16'h00FF, 0, 1'b0, 16'h0103);
        push(16'h0080, 16'hFF00, 0, 1'b0, 16'h0104);
        push(16'h0080, 16'hFFFF, 0, 1'b1, 16'h0105);
        push(16'h0000, 16'h0000, 0, 1'b0, 16'hFFFF);
        push(16'h0000, 16'h0000, 0, 1'b0, 16'h0000);  // wrap
        drain("phase2_drain");
        sb_en = 1'b0;

        // Abort a LOAD with reset: R2 must keep its earlier value
        mem[10'h040] = 16'h1234;
        wait_for(3'd2, 16'h0003, "reset_load_reached");
        rst_n = 1'b0;
        #1;
        chk_eq("rstload_pc",    pc,     32'h0000);
        chk_eq("rstload_state", state,  32'd0);
        chk_eq("rstload_we",    reg_we, 32'h0000);
        repeat (2) @(negedge clk);
        #1;
        chk_eq("rstload_r2", rf[2], 32'hBEEF);

        mem[10'h000] = 16'hA000;  // illegal op
        rst_n = 1'b1;
        wait_for(3'd2, 16'h0000, "illegal_exec_reached");
        @(negedge clk); #1;
`ifdef CR16_CTRL_HALT_ON_ILLEGAL_EN
        chk_eq("illegal_state",  state,  32'd4);
        chk_eq("illegal_halted", halted, 32'd1);
        chk_eq("illegal_pc",     pc,     32'h0000);
        repeat (3) @(negedge clk);
        #1;
        chk_eq("halt_hold_state", state,  32'd4);
        chk_eq("halt_hold_pc",    pc,     32'h0000);
        chk_eq("halt_hold_we",    reg_we, 32'h0000);
`else
        chk_eq("illegal_state",  state,  32'd0);
        chk_eq("illegal_halted", halted, 32'd0);
        chk_eq("illegal_pc",     pc,     32'h0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
- Multi-cycle CR16 controller that drives the `datapath` control inputs from fetched instructions.
- Fetches each instruction from memory, decodes it, sequences register, flag and memory writes, and maintains the PC.
- Sits between instruction/data memory and `datapath`: consumes datapath O_A and status flags; produces the datapath control bundle.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- I_CLK  in  1  clock; all state updates on the rising edge.
- I_NRESET  in  1  reset, asynchronous and active-low.
- I_ENABLE  in  1  0 = freeze FSM/PC and suppress all write strobes.
- I_MEM_DATA  in  16  memory read data; synchronous read, 1-cycle latency.
- I_A  in  16  datapath O_A; load/store address, jump target.
- I_STATUS_FLAGS  in  5  datapath flags {C,L,F,Z,N}, bit4..bit0.
- O_MEM_ADDR  out  16  memory address.
- O_MEM_WE  out  1  memory write strobe.
- O_REG_WRITE_ENABLE  out  16  one-hot register write enable.
- O_REG_A_SELECT  out  4  datapath A select.
- O_REG_B_SELECT  out  4  datapath B select.
- O_IMMEDIATE_SELECT  out  1  datapath B operand = O_IMMEDIATE.
- O_IMMEDIATE  out  16  extended immediate.
- O_OPCODE  out  4  ALU opcode (ADD=0 … ARSH=14).
- O_FLAGS_WRITE_ENABLE  out  1  latch ALU flags this cycle.
- O_REGFILE_DATA  out  16  alternate register write data.
- O_REGFILE_DATA_SELECT  out  1  register write source = O_REGFILE_DATA.
- O_PC  out  16  current PC.
- O_STATE  out  3  FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4.
- O_HALTED  out  1  1 while in HALT.

Behaviour:
- Reset (async):
  - State=FETCH, PC=PC_RESET, IR=0.
  - All strobes/selects/data outputs 0; O_HALTED=0.
  - Reset mid-instruction aborts it; no write occurs.
- FETCH: O_MEM_ADDR=PC -> DECODE.
- DECODE: IR <= I_MEM_DATA at the edge -> EXECUTE.
- EXECUTE: controls are combinational from IR; writes commit at the edge.
- Default next state is FETCH with PC <= PC+1 (16-bit wrap: 16'hFFFF+1 = 0).
- Outside EXECUTE/WRITEBACK: O_REG_WRITE_ENABLE, O_MEM_WE and O_FLAGS_WRITE_ENABLE are all 0.
- Instruction fields: op=[15:12], Rd=[11:8], [7:4]=ext, Rs=[3:0], imm8=[7:0]. Register ALU operations use A=Rd, B=Rs.
- Decode by op:
  - op0 RR: ext 0..14 -> ALU opcode=ext, write Rd, flags WE=1; ext 15 = MOV: write Rd <= Rs via REGFILE_DATA = I_A with A=Rs, flags WE=0.
  - op1 ADDI: ADD, imm = sign-extended imm8, write Rd, flags WE=1.
  - op2 MOVI: Rd <= zero-extended imm8 via REGFILE_DATA.
  - op3 LUI: Rd <= {imm8,8'h00} via REGFILE_DATA.
  - op4 CMPI: SUB with sign-extended imm8, flags WE=1, no register write.
  - op5 LOAD: A=Rs, O_MEM_ADDR=I_A -> WRITEBACK; there Rd <= I_MEM_DATA via REGFILE_DATA; then FETCH, PC+1.
  - op6 STOR: A=Rs, B=Rd, O_MEM_ADDR=I_A, O_MEM_WE=1. Write data is datapath O_B, external to this block.
  - op7 Bcond: cond=Rd; if true, PC <= PC + sign-extended imm8 (PC = address of this branch); else PC+1.
  - op8 Jcond: cond=Rd, A=Rs; if true, PC <= I_A.
  - op9 JAL: Rd <= PC+1 via REGFILE_DATA; A=Rs, PC <= I_A. If Rd==Rs, the jump uses the old Rs value.
  - op10-15: illegal; treated as NOP (PC+1).
- Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; 14 UC always; others never.
- Conditions are evaluated on I_STATUS_FLAGS in EXECUTE.
- Latency: LOAD 4 cycles; all other instructions 3 cycles.
- I_ENABLE=0: state, PC and IR hold; all write strobes 0. Resuming continues in the same state.

Optional Feature:
- CR16_CTRL_HALT_ON_ILLEGAL_EN defined: an illegal op in EXECUTE -> HALT. HALT makes no writes, holds PC, drives O_HALTED=1, and exits only on reset.
- Undefined: illegal ops are NOP; HALT unreachable; O_HALTED tied 0.

Test Plan:
- Reset with PC_RESET=0 -> O_PC=0, O_STATE=0, all WE=0. Memory {0:MOVI R1,5; 1:ADDI R1,3} -> after 6 cycles R1 write data = 8, O_REG_WRITE_ENABLE=16'h0002, O_PC=2.
- LOAD R2,[R3] with R3=0x0040, mem[0x40]=0xBEEF:
  - EXECUTE: O_MEM_ADDR=0x0040.
  - WRITEBACK: REGFILE_DATA=0xBEEF, WE=16'h0004.
  - Next FETCH: PC+1.
- Bcond EQ, imm8=0xFE at PC=10 -> Z=1: PC=8; Z=0: PC=11.
- JAL R15,R4 at PC=0x0020 with R4=0x0100 -> R15 write data=0x0021, O_PC=0x0100. PC=0xFFFF NOP -> O_PC=0x0000.
- I_ENABLE=0 during EXECUTE of STOR -> O_MEM_WE=0, state holds. Re-enable -> single write. Async reset mid-LOAD -> no register write, O_PC=PC_RESET.
- Illegal op 0xA000: with macro -> O_HALTED=1, O_PC frozen; without -> PC+1.
